// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared types and constants for the protobuf stream parser
package pb_pkg;

    localparam int MAX_VARINT_BYTES = 10;
    localparam int MAX_KEY_BYTES    = 5;

    localparam logic [2:0] WT_VARINT = 3'd0;
    localparam logic [2:0] WT_I64    = 3'd1;
    localparam logic [2:0] WT_LEN    = 3'd2;
    localparam logic [2:0] WT_I32    = 3'd5;

    typedef enum logic [2:0] {
        ST_KEY,
        ST_VARINT,
        ST_FIXED,
        ST_LEN,
        ST_PAYLOAD,
        ST_DRAIN
    } pb_state_e;

    typedef enum logic [1:0] {
        KIND_SCALAR  = 2'd0,
        KIND_LEN_HDR = 2'd1,
        KIND_PAYLOAD = 2'd2
    } pb_kind_e;

    typedef enum logic [1:0] {
        ERR_ILLEGAL_WT = 2'd0,
        ERR_OVERLONG   = 2'd1,
        ERR_TRUNC      = 2'd2,
        ERR_FIELD_ZERO = 2'd3
    } pb_err_e;

    // Wire types the parser knows how to sequence; groups (3/4) are rejected.
    function automatic logic wt_legal(input logic [2:0] wt);
        return (wt == WT_VARINT) || (wt == WT_I64) || (wt == WT_LEN) || (wt == WT_I32);
    endfunction

endpackage

// File: rtl/pb_varint_accum.sv
// rtl/pb_varint_accum.sv - base-128 varint accumulator shared by key, value and length decode
module pb_varint_accum (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    input  logic [3:0]  max_bytes,
    output logic [63:0] value,
    output logic        done,
    output logic        overlong
);

    logic [63:0] acc;
    logic [3:0]  count;
    logic [6:0]  shamt;

    // Payload bits of byte i land at 7*i; anything shifted past bit 63 falls off.
    assign shamt    = {3'b000, count} * 7'd7;
    assign value    = acc | ({57'd0, data[6:0]} << shamt);
    assign done     = !data[7];
    assign overlong = data[7] && (count == (max_bytes - 4'd1));

    // Accumulate until the terminating byte, then self-clear for the next varint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= 64'd0;
            count <= 4'd0;
        end else if (clear) begin
            acc   <= 64'd0;
            count <= 4'd0;
        end else if (en) begin
            if (done) begin
                acc   <= 64'd0;
                count <= 4'd0;
            end else begin
                acc   <= value;
                count <= count + 4'd1;
            end
        end
    end

endmodule

// File: rtl/pb_stream_parser.sv
// rtl/pb_stream_parser.sv - streaming protobuf wire-format field parser
module pb_stream_parser #(
    parameter int MAX_VARINT_BYTES = 10,
    parameter int MAX_KEY_BYTES    = 5,
    parameter int LEN_W            = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_kind,
    output logic [28:0] out_field_number,
    output logic [2:0]  out_wire_type,
    output logic [63:0] out_value,
    output logic        out_last,
    output logic        err_valid,
    output logic [1:0]  err_code
);

    import pb_pkg::*;

    localparam logic [3:0] VARINT_MAX = 4'(MAX_VARINT_BYTES);
    localparam logic [3:0] KEY_MAX    = 4'(MAX_KEY_BYTES);

    pb_state_e         state, state_d;
    logic [28:0]       field_q, field_d;
    logic [2:0]        wt_q, wt_d;
    logic [2:0]        fixed_idx, fixed_idx_d;
    logic [63:0]       fixed_val, fixed_val_d;
    logic [LEN_W-1:0]  len_cnt, len_cnt_d;

    logic              accept;
    logic              acc_en, acc_clear, acc_done, acc_overlong;
    logic [63:0]       acc_value;
    logic [3:0]        acc_max;

    logic              emit;
    pb_kind_e          emit_kind;
    logic [63:0]       emit_value;
    logic              err_hit;
    pb_err_e           err_sel;

    logic [2:0]        key_wt;
    logic [28:0]       key_field;
    logic [2:0]        fixed_last;
    logic [63:0]       fixed_merge;
    logic              len_too_big;

    assign accept      = in_valid && in_ready;
    assign acc_max     = (state == ST_KEY) ? KEY_MAX : VARINT_MAX;
    assign acc_clear   = err_hit;
    assign key_wt      = acc_value[2:0];
    assign key_field   = acc_value[31:3];
    assign fixed_last  = (wt_q == WT_I64) ? 3'd7 : 3'd3;
    assign fixed_merge = fixed_val | ({56'd0, in_data} << {fixed_idx, 3'b000});
    assign len_too_big = (acc_value >> LEN_W) != 64'd0;

    pb_varint_accum u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (acc_clear),
        .en        (acc_en),
        .data      (in_data),
        .max_bytes (acc_max),
        .value     (acc_value),
        .done      (acc_done),
        .overlong  (acc_overlong)
    );

    // Per-byte decode: next state, field context, event to emit, or error to raise.
    always_comb begin
        state_d     = state;
        field_d     = field_q;
        wt_d        = wt_q;
        fixed_idx_d = fixed_idx;
        fixed_val_d = fixed_val;
        len_cnt_d   = len_cnt;
        acc_en      = 1'b0;
        emit        = 1'b0;
        emit_kind   = KIND_SCALAR;
        emit_value  = 64'd0;
        err_hit     = 1'b0;
        err_sel     = ERR_TRUNC;

        if (accept) begin
            case (state)
                ST_KEY: begin
                    acc_en = 1'b1;
                    if (acc_overlong) begin
                        err_hit = 1'b1;
                        err_sel = ERR_OVERLONG;
                    end else if (acc_done) begin
                        if (!wt_legal(key_wt)) begin
                            err_hit = 1'b1;
                            err_sel = ERR_ILLEGAL_WT;
                        end else if (key_field == 29'd0) begin
                            err_hit = 1'b1;
                            err_sel = ERR_FIELD_ZERO;
                        end else if (in_last) begin
                            err_hit = 1'b1;
                        end else begin
                            field_d     = key_field;
                            wt_d        = key_wt;
                            fixed_idx_d = 3'd0;
                            fixed_val_d = 64'd0;
                            case (key_wt)
                                WT_VARINT: state_d = ST_VARINT;
                                WT_LEN:    state_d = ST_LEN;
                                default:   state_d = ST_FIXED;
                            endcase
                        end
                    end else if (in_last) begin
                        err_hit = 1'b1;
                    end
                end
                ST_VARINT: begin
                    acc_en = 1'b1;
                    if (acc_overlong) begin
                        err_hit = 1'b1;
                        err_sel = ERR_OVERLONG;
                    end else if (acc_done) begin
                        emit       = 1'b1;
                        emit_value = acc_value;
                        state_d    = ST_KEY;
                    end else if (in_last) begin
                        err_hit = 1'b1;
                    end
                end
                ST_FIXED: begin
                    if (fixed_idx == fixed_last) begin
                        emit       = 1'b1;
                        emit_value = fixed_merge;
                        state_d    = ST_KEY;
                    end else if (in_last) begin
                        err_hit = 1'b1;
                    end else begin
                        fixed_val_d = fixed_merge;
                        fixed_idx_d = fixed_idx + 3'd1;
                    end
                end
                ST_LEN: begin
                    acc_en    = 1'b1;
                    emit_kind = KIND_LEN_HDR;
                    if (acc_overlong) begin
                        err_hit = 1'b1;
                        err_sel = ERR_OVERLONG;
                    end else if (acc_done) begin
                        if (len_too_big) begin
                            err_hit = 1'b1;
                            err_sel = ERR_OVERLONG;
                        end else if (acc_value == 64'd0) begin
                            emit       = 1'b1;
                            emit_value = 64'd0;
                            state_d    = ST_KEY;
                        end else if (in_last) begin
                            err_hit = 1'b1;
                        end else begin
                            emit       = 1'b1;
                            emit_value = acc_value;
                            len_cnt_d  = acc_value[LEN_W-1:0];
                            state_d    = ST_PAYLOAD;
                        end
                    end else if (in_last) begin
                        err_hit = 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    emit_kind  = KIND_PAYLOAD;
                    emit_value = {56'd0, in_data};
                    if (len_cnt == LEN_W'(1)) begin
                        emit    = 1'b1;
                        state_d = ST_KEY;
                    end else if (in_last) begin
                        err_hit = 1'b1;
                    end else begin
                        emit      = 1'b1;
                        len_cnt_d = len_cnt - LEN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (in_last) state_d = ST_KEY;
                end
                default: state_d = ST_KEY;
            endcase

            // A message boundary ends any error recovery immediately.
            if (err_hit) state_d = in_last ? ST_KEY : ST_DRAIN;
        end
    end

    // State and per-field context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_KEY;
            field_q   <= 29'd0;
            wt_q      <= 3'd0;
            fixed_idx <= 3'd0;
            fixed_val <= 64'd0;
            len_cnt   <= '0;
        end else begin
            state     <= state_d;
            field_q   <= field_d;
            wt_q      <= wt_d;
            fixed_idx <= fixed_idx_d;
            fixed_val <= fixed_val_d;
            len_cnt   <= len_cnt_d;
        end
    end

    // Single event slot, one-cycle error pulse, and ready that blocks while the slot is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            out_kind         <= 2'd0;
            out_field_number <= 29'd0;
            out_wire_type    <= 3'd0;
            out_value        <= 64'd0;
            out_last         <= 1'b0;
            err_valid        <= 1'b0;
            err_code         <= 2'd0;
            in_ready         <= 1'b0;
        end else begin
            err_valid <= err_hit;
            if (err_hit) err_code <= err_sel;
            if (emit) begin
                out_valid        <= 1'b1;
                out_kind         <= emit_kind;
                out_field_number <= field_q;
                out_wire_type    <= wt_q;
                out_value        <= emit_value;
                out_last         <= in_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            in_ready <= !(emit || (out_valid && !out_ready));
        end
    end

endmodule

// File: tb/tb_pb_stream_parser.sv
// tb/tb_pb_stream_parser.sv - self-checking bench for pb_stream_parser
module tb_pb_stream_parser;

    localparam logic [1:0] K_SCALAR = 2'd0, K_LEN_HDR = 2'd1, K_PAYLOAD = 2'd2;
    localparam logic [1:0] E_ILLEGAL = 2'd0, E_OVERLONG = 2'd1, E_TRUNC = 2'd2, E_FIELD_ZERO = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [28:0] out_field_number;
    logic [2:0]  out_wire_type;
    logic [63:0] out_value;
    logic        out_last;
    logic        err_valid;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    pb_stream_parser dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_last          (in_last),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_kind         (out_kind),
        .out_field_number (out_field_number),
        .out_wire_type    (out_wire_type),
        .out_value        (out_value),
        .out_last         (out_last),
        .err_valid        (err_valid),
        .err_code         (err_code)
    );

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [1:0]  kind;
        logic [28:0] fn;
        logic [2:0]  wt;
        logic [63:0] val;
        bit          last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic pin(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic push_ev(input logic [1:0] k, input logic [28:0] fn, input logic [2:0] wt,
                           input logic [63:0] v, input bit last);
        exp_t e;
        e.is_err = 1'b0; e.code = 2'd0; e.kind = k; e.fn = fn; e.wt = wt; e.val = v; e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1; e.code = code; e.kind = 2'd0; e.fn = 29'd0; e.wt = 3'd0; e.val = 64'd0; e.last = 1'b0;
        exp_q.push_back(e);
    endtask

    // Software varint reader: st 0 = complete, 1 = too many bytes, 2 = message ended inside it.
    task automatic mparse(input logic [7:0] m[$], inout int pos, input int maxb,
                          output logic [63:0] v, output int st);
        logic [7:0] x;
        v  = 64'd0;
        st = 2;
        for (int k = 0; k < 16; k++) begin
            x = m[pos];
            pos++;
            if (k < 10) v = v | ({57'd0, x[6:0]} << (7 * k));
            if (!x[7]) begin st = 0; return; end
            if (k == maxb - 1) begin st = 1; return; end
            if (pos == m.size()) begin st = 2; return; end
        end
    endtask

    // Decodes one whole message (last byte = in_last) into the expected event/error list.
    task automatic model_msg(input logic [7:0] m[$]);
        int          pos, n, st, flen;
        logic [63:0] key, v;
        logic [2:0]  wt;
        logic [28:0] fn;
        pos = 0;
        n   = m.size();
        while (pos < n) begin
            mparse(m, pos, 5, key, st);
            if (st == 1) begin push_err(E_OVERLONG); return; end
            if (st == 2) begin push_err(E_TRUNC); return; end
            wt = key[2:0];
            fn = key[31:3];
            if (!(wt == 3'd0 || wt == 3'd1 || wt == 3'd2 || wt == 3'd5)) begin push_err(E_ILLEGAL); return; end
            if (fn == 29'd0) begin push_err(E_FIELD_ZERO); return; end
            if (pos == n) begin push_err(E_TRUNC); return; end
            if (wt == 3'd0) begin
                mparse(m, pos, 10, v, st);
                if (st == 1) begin push_err(E_OVERLONG); return; end
                if (st == 2) begin push_err(E_TRUNC); return; end
                push_ev(K_SCALAR, fn, wt, v, pos == n);
            end else if (wt == 3'd2) begin
                mparse(m, pos, 10, v, st);
                if (st == 1) begin push_err(E_OVERLONG); return; end
                if (st == 2) begin push_err(E_TRUNC); return; end
                if (v[63:32] != 32'd0) begin push_err(E_OVERLONG); return; end
                if (v == 64'd0) begin
                    push_ev(K_LEN_HDR, fn, wt, v, pos == n);
                end else begin
                    if (pos == n) begin push_err(E_TRUNC); return; end
                    push_ev(K_LEN_HDR, fn, wt, v, 1'b0);
                    for (longint unsigned j = 0; j < v; j++) begin
                        pos++;
                        if (j == v - 1) push_ev(K_PAYLOAD, fn, wt, {56'd0, m[pos-1]}, pos == n);
                        else if (pos == n) begin push_err(E_TRUNC); return; end
                        else push_ev(K_PAYLOAD, fn, wt, {56'd0, m[pos-1]}, 1'b0);
                    end
                end
            end else begin
                flen = (wt == 3'd1) ? 8 : 4;
                if (n - pos < flen) begin push_err(E_TRUNC); return; end
                v = 64'd0;
                for (int j = 0; j < flen; j++) v = v | ({56'd0, m[pos+j]} << (8 * j));
                pos += flen;
                push_ev(K_SCALAR, fn, wt, v, pos == n);
            end
        end
    endtask

    // Holds the byte until the parser takes it; ready is sampled mid-cycle.
    task automatic wait_accept();
        int t;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got in_ready=0 for 200 cycles, required 1");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input logic [7:0] m[$], input bit mark_last);
        for (int i = 0; i < m.size(); i++) begin
            in_valid = 1'b1;
            in_data  = m[i];
            in_last  = mark_last && (i == m.size() - 1);
            wait_accept();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic settle(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d expected items still unseen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run(input string name, input logic [7:0] m[$]);
        model_msg(m);
        send_msg(m, 1'b1);
        settle(name);
    endtask

    // Compare process: every handshake and error pulse against the model, plus hold stability.
    bit          held = 1'b0;
    logic [1:0]  h_kind;
    logic [28:0] h_fn;
    logic [2:0]  h_wt;
    logic [63:0] h_val;
    logic        h_last;
    exp_t        e_mon;

    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checks++;
                if (!(out_valid && out_kind == h_kind && out_field_number == h_fn &&
                      out_wire_type == h_wt && out_value == h_val && out_last == h_last)) begin
                    errors++;
                    $display("FAIL hold_stable: got valid=%0b kind=%0d val=%h, required valid=1 kind=%0d val=%h",
                             out_valid, out_kind, out_value, h_kind, h_val);
                end
            end
            held   = out_valid && !out_ready;
            h_kind = out_kind; h_fn = out_field_number; h_wt = out_wire_type;
            h_val  = out_value; h_last = out_last;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL event: got kind=%0d val=%h, required no event", out_kind, out_value);
                end else begin
                    e_mon = exp_q.pop_front();
                    if (e_mon.is_err || out_kind != e_mon.kind || out_field_number != e_mon.fn ||
                        out_wire_type != e_mon.wt || out_value != e_mon.val || out_last != e_mon.last) begin
                        errors++;
                        $display("FAIL event: got err=0 kind=%0d fn=%0d wt=%0d val=%h last=%0b, required err=%0b code=%0d kind=%0d fn=%0d wt=%0d val=%h last=%0b",
                                 out_kind, out_field_number, out_wire_type, out_value, out_last,
                                 e_mon.is_err, e_mon.code, e_mon.kind, e_mon.fn, e_mon.wt, e_mon.val, e_mon.last);
                    end
                end
            end
            if (err_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL error: got code=%0d, required no error", err_code);
                end else begin
                    e_mon = exp_q.pop_front();
                    if (!e_mon.is_err || err_code != e_mon.code) begin
                        errors++;
                        $display("FAIL error: got code=%0d, required err=%0b code=%0d kind=%0d val=%h",
                                 err_code, e_mon.is_err, e_mon.code, e_mon.kind, e_mon.val);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish after 400000 ns, required finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] m[$];
    int         t;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        pin("rst_out_valid", out_valid, 0);
        pin("rst_in_ready", in_ready, 0);
        pin("rst_err_valid", err_valid, 0);
        pin("rst_out_value", out_value, 0);
        pin("rst_out_last", out_last, 0);
        rst_n = 1'b1;

        // Varint scalar 150.
        m = '{8'h08, 8'h96, 8'h01};
        model_msg(m);
        pin("model_t1_count", exp_q.size(), 1);
        pin("model_t1_value", exp_q[0].val, 150);
        pin("model_t1_last", exp_q[0].last, 1);
        send_msg(m, 1'b1);
        settle("t1");

        // Length-delimited "testing".
        m = '{8'h12, 8'h07, 8'h74, 8'h65, 8'h73, 8'h74, 8'h69, 8'h6e, 8'h67};
        model_msg(m);
        pin("model_t2_count", exp_q.size(), 8);
        pin("model_t2_hdr", exp_q[0].val, 7);
        pin("model_t2_fn", exp_q[0].fn, 2);
        pin("model_t2_tail", exp_q[7].val, 64'h67);
        pin("model_t2_tail_last", exp_q[7].last, 1);
        send_msg(m, 1'b1);
        settle("t2");

        // fixed32 then fixed64 in one message.
        m = '{8'h0D, 8'h01, 8'h02, 8'h03, 8'h04, 8'h19,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        model_msg(m);
        pin("model_t3_f32", exp_q[0].val, 64'h0000_0000_0403_0201);
        pin("model_t3_f64", exp_q[1].val, 64'h0807_0605_0403_0201);
        pin("model_t3_fn", exp_q[1].fn, 3);
        send_msg(m, 1'b1);
        settle("t3");

        // Illegal wire type, dropped tail, then a clean message.
        m = '{8'h0B, 8'hAA, 8'hBB, 8'hCC};
        model_msg(m);
        pin("model_t4_code", exp_q[0].code, E_ILLEGAL);
        send_msg(m, 1'b1);
        settle("t4");
        run("t4b", '{8'h08, 8'h01});

        // Value varint with a continuation bit on its tenth byte.
        m = '{8'h08};
        for (int i = 0; i < 10; i++) m.push_back(8'hFF);
        model_msg(m);
        pin("model_t5_code", exp_q[0].code, E_OVERLONG);
        send_msg(m, 1'b1);
        settle("t5");

        // Tenth byte terminates; bits above 63 are discarded.
        m = '{8'h08};
        for (int i = 0; i < 9; i++) m.push_back(8'hFF);
        m.push_back(8'h7F);
        run("t6", m);

        // Truncated varint, truncated fixed32, field zero.
        run("t7", '{8'h08, 8'h96});
        run("t8", '{8'h0D, 8'h01, 8'h02});
        run("t9", '{8'h00, 8'h01});

        // Scalar 300 then an empty length field closing the message.
        m = '{8'h08, 8'hAC, 8'h02, 8'h1A, 8'h00};
        model_msg(m);
        pin("model_t10_value", exp_q[0].val, 300);
        send_msg(m, 1'b1);
        settle("t10");

        // Length 2^32 overflows, 2^32-1 on the last byte truncates, 5-byte key overflows.
        run("t11", '{8'h12, 8'h80, 8'h80, 8'h80, 8'h80, 8'h10});
        run("t12", '{8'h12, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F});
        run("t13", '{8'h88, 8'h80, 8'h80, 8'h80, 8'h80, 8'h01});

        // Consumer stall in the middle of a payload.
        m = '{8'h12, 8'h03, 8'h61, 8'h62, 8'h63};
        model_msg(m);
        fork
            send_msg(m, 1'b1);
            begin
                t = 0;
                do begin @(negedge clk); t++; end while (!(out_valid && out_kind == K_LEN_HDR) && t < 100);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                t = 0;
                do begin @(negedge clk); t++; end while (!out_valid && t < 100);
                pin("stall_kind", out_kind, K_PAYLOAD);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    pin("stall_in_ready", in_ready, 0);
                    pin("stall_out_valid", out_valid, 1);
                    pin("stall_value", out_value, 64'h61);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        settle("stall");

        // Reset while a payload event sits in the slot.
        m = '{8'h12, 8'h05, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        model_msg(m);
        m = '{8'h12, 8'h05, 8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0);
        pin("pre_rst_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        pin("mid_rst_out_valid", out_valid, 0);
        pin("mid_rst_out_value", out_value, 0);
        pin("mid_rst_out_kind", out_kind, 0);
        pin("mid_rst_in_ready", in_ready, 0);
        pin("mid_rst_pending", exp_q.size(), 3);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run("post_rst", '{8'h08, 8'h01});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
